// File: rtl/ace_xack_tracker.sv
// ace_xack_tracker: counts delivered R bursts and B responses that still await
// RACK / WACK from an ACE master, and back-pressures each channel once its
// outstanding count reaches MaxRespTrans. All gating is combinational; no payload
// is stored.
//
// Optional feature: define ACE_XACK_TRACKER_ERR_EN to build the sticky
// ack_err_o register. Otherwise ack_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   up_r_valid_i, up_r_last_i       R valid / last beat from the responder
//   up_r_ready_o                    R ready to the responder
//   dn_r_valid_o, dn_r_ready_i      R handshake toward the ACE master
//   rack_i                          RACK from the ACE master
//   up_b_valid_i, up_b_ready_o      B handshake with the responder
//   dn_b_valid_o, dn_b_ready_i      B handshake toward the ACE master
//   wack_i                          WACK from the ACE master
//   r_pend_o, b_pend_o              registered outstanding counts
//   idle_o                          both counts are zero
//   ack_err_o                       sticky RACK/WACK-with-nothing-pending flag
module ace_xack_tracker #(
    parameter int unsigned MaxRespTrans = 8,
    localparam int unsigned CntW = $clog2(MaxRespTrans + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            up_r_valid_i,
    input  logic            up_r_last_i,
    output logic            up_r_ready_o,
    output logic            dn_r_valid_o,
    input  logic            dn_r_ready_i,
    input  logic            rack_i,
    input  logic            up_b_valid_i,
    output logic            up_b_ready_o,
    output logic            dn_b_valid_o,
    input  logic            dn_b_ready_i,
    input  logic            wack_i,
    output logic [CntW-1:0] r_pend_o,
    output logic [CntW-1:0] b_pend_o,
    output logic            idle_o,
    output logic            ack_err_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxRespTrans);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] r_pend_q, r_pend_d;
    logic [CntW-1:0] b_pend_q, b_pend_d;
    logic            r_full, b_full;
    logic            r_done, b_done;
    logic            r_ack, b_ack;

    // Channel gating: a full counter blocks both valid downstream and ready upstream.
    always_comb begin
        r_full       = (r_pend_q == CntMax);
        b_full       = (b_pend_q == CntMax);
        dn_r_valid_o = up_r_valid_i & ~r_full;
        up_r_ready_o = dn_r_ready_i & ~r_full;
        dn_b_valid_o = up_b_valid_i & ~b_full;
        up_b_ready_o = dn_b_ready_i & ~b_full;
    end

    // Completion and acknowledge events; acks with nothing pending are dropped.
    always_comb begin
        r_done = dn_r_valid_o & dn_r_ready_i & up_r_last_i;
        b_done = dn_b_valid_o & dn_b_ready_i;
        r_ack  = rack_i & (r_pend_q != '0);
        b_ack  = wack_i & (b_pend_q != '0);
    end

    // Next counts: done and ack in the same cycle cancel out.
    always_comb begin
        r_pend_d = r_pend_q;
        b_pend_d = b_pend_q;
        if (r_done && !r_ack) begin
            r_pend_d = r_pend_q + CntOne;
        end else if (!r_done && r_ack) begin
            r_pend_d = r_pend_q - CntOne;
        end
        if (b_done && !b_ack) begin
            b_pend_d = b_pend_q + CntOne;
        end else if (!b_done && b_ack) begin
            b_pend_d = b_pend_q - CntOne;
        end
    end

    // Outstanding-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_q <= '0;
            b_pend_q <= '0;
        end else begin
            r_pend_q <= r_pend_d;
            b_pend_q <= b_pend_d;
        end
    end

    assign r_pend_o = r_pend_q;
    assign b_pend_o = b_pend_q;
    assign idle_o   = (r_pend_q == '0) && (b_pend_q == '0);

`ifdef ACE_XACK_TRACKER_ERR_EN
    logic ack_viol;
    logic ack_err_q;

    // An xACK with a zero registered count is a violation, including one that
    // coincides with the first completion (xACK must trail the handshake).
    assign ack_viol = (rack_i && (r_pend_q == '0)) || (wack_i && (b_pend_q == '0));

    // Sticky until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_err_q <= 1'b0;
        end else if (ack_viol) begin
            ack_err_q <= 1'b1;
        end
    end

    assign ack_err_o = ack_err_q;
`else
    assign ack_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ace_xack_tracker.sv
// Bench for ace_xack_tracker: a MaxRespTrans=2 instance driven by a vector table
// and short directed sequences, and a default (8) instance driven by random
// traffic against a counting scoreboard.
module tb_ace_xack_tracker;

    localparam int unsigned SmallMax = 2;
    localparam int unsigned LargeMax = 8;
    localparam int unsigned SW = $clog2(SmallMax + 1);
    localparam int unsigned LW = $clog2(LargeMax + 1);

`ifdef ACE_XACK_TRACKER_ERR_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    typedef struct packed {
        logic r_valid;
        logic r_last;
        logic r_ready;
        logic rack;
        logic b_valid;
        logic b_ready;
        logic wack;
    } stim_t;

    typedef struct {
        stim_t       in;
        int unsigned r_pend;
        logic        dn_r_valid;
        logic        up_r_ready;
        int unsigned b_pend;
        logic        dn_b_valid;
        logic        up_b_ready;
        logic        idle;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    stim_t s_in, l_in;

    logic          s_up_r_ready, s_dn_r_valid, s_up_b_ready, s_dn_b_valid, s_idle, s_err;
    logic [SW-1:0] s_r_pend, s_b_pend;
    logic          l_up_r_ready, l_dn_r_valid, l_up_b_ready, l_dn_b_valid, l_idle, l_err;
    logic [LW-1:0] l_r_pend, l_b_pend;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ace_xack_tracker #(.MaxRespTrans(SmallMax)) u_small (
        .clk_i(clk), .rst_i(rst),
        .up_r_valid_i(s_in.r_valid), .up_r_last_i(s_in.r_last), .up_r_ready_o(s_up_r_ready),
        .dn_r_valid_o(s_dn_r_valid), .dn_r_ready_i(s_in.r_ready), .rack_i(s_in.rack),
        .up_b_valid_i(s_in.b_valid), .up_b_ready_o(s_up_b_ready),
        .dn_b_valid_o(s_dn_b_valid), .dn_b_ready_i(s_in.b_ready), .wack_i(s_in.wack),
        .r_pend_o(s_r_pend), .b_pend_o(s_b_pend), .idle_o(s_idle), .ack_err_o(s_err)
    );

    ace_xack_tracker #(.MaxRespTrans(LargeMax)) u_large (
        .clk_i(clk), .rst_i(rst),
        .up_r_valid_i(l_in.r_valid), .up_r_last_i(l_in.r_last), .up_r_ready_o(l_up_r_ready),
        .dn_r_valid_o(l_dn_r_valid), .dn_r_ready_i(l_in.r_ready), .rack_i(l_in.rack),
        .up_b_valid_i(l_in.b_valid), .up_b_ready_o(l_up_b_ready),
        .dn_b_valid_o(l_dn_b_valid), .dn_b_ready_i(l_in.b_ready), .wack_i(l_in.wack),
        .r_pend_o(l_r_pend), .b_pend_o(l_b_pend), .idle_o(l_idle), .ack_err_o(l_err)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input stim_t in, input int unsigned rp, input logic dnrv,
                                input logic uprr, input int unsigned bp, input logic dnbv,
                                input logic upbr, input logic idle);
        vec_t v;
        v.in = in; v.r_pend = rp; v.dn_r_valid = dnrv; v.up_r_ready = uprr;
        v.b_pend = bp; v.dn_b_valid = dnbv; v.up_b_ready = upbr; v.idle = idle;
        return v;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t        vecs[18];
    stim_t       st;
    int          r_model, b_model;
    int          r_due[$], b_due[$];
    int          idx;
    logic        r_full, b_full;

    initial begin
        // Stimulus bits: r_valid r_last r_ready rack b_valid b_ready wack
        vecs[0]  = mk(7'b1010000, 0, 1, 1, 0, 0, 0, 1);
        vecs[1]  = mk(7'b1010000, 0, 1, 1, 0, 0, 0, 1);
        vecs[2]  = mk(7'b1010000, 0, 1, 1, 0, 0, 0, 1);
        vecs[3]  = mk(7'b1110000, 0, 1, 1, 0, 0, 0, 1);
        vecs[4]  = mk(7'b1010000, 1, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mk(7'b1010000, 1, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(7'b1010000, 1, 1, 1, 0, 0, 0, 0);
        vecs[7]  = mk(7'b1110000, 1, 1, 1, 0, 0, 0, 0);
        vecs[8]  = mk(7'b1010000, 2, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(7'b1011000, 2, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(7'b1000000, 1, 1, 0, 0, 0, 0, 0);
        vecs[11] = mk(7'b0011000, 1, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(7'b0000000, 0, 0, 0, 0, 0, 0, 1);
        vecs[13] = mk(7'b0000110, 0, 0, 0, 0, 1, 1, 1);
        vecs[14] = mk(7'b0000111, 0, 0, 0, 1, 1, 1, 0);
        vecs[15] = mk(7'b0000000, 0, 0, 0, 1, 0, 0, 0);
        vecs[16] = mk(7'b0000001, 0, 0, 0, 1, 0, 0, 0);
        vecs[17] = mk(7'b0000000, 0, 0, 0, 0, 0, 0, 1);

        rst  = 1'b1;
        s_in = '0;
        l_in = '0;
        #1;
        check("reset_r_pend", 32'(s_r_pend), 0);
        check("reset_b_pend", 32'(s_b_pend), 0);
        check("reset_idle", 32'(s_idle), 1);
        check("reset_err", 32'(s_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table on the MaxRespTrans=2 instance.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            s_in = vecs[i].in;
            #1;
            check($sformatf("vec%0d_r_pend", i), 32'(s_r_pend), vecs[i].r_pend);
            check($sformatf("vec%0d_dn_r_valid", i), 32'(s_dn_r_valid), 32'(vecs[i].dn_r_valid));
            check($sformatf("vec%0d_up_r_ready", i), 32'(s_up_r_ready), 32'(vecs[i].up_r_ready));
            check($sformatf("vec%0d_b_pend", i), 32'(s_b_pend), vecs[i].b_pend);
            check($sformatf("vec%0d_dn_b_valid", i), 32'(s_dn_b_valid), 32'(vecs[i].dn_b_valid));
            check($sformatf("vec%0d_up_b_ready", i), 32'(s_up_b_ready), 32'(vecs[i].up_b_ready));
            check($sformatf("vec%0d_idle", i), 32'(s_idle), 32'(vecs[i].idle));
            check($sformatf("vec%0d_err", i), 32'(s_err), 0);
        end

        // RACK with nothing pending.
        @(negedge clk);
        s_in = 7'b0001000;
        @(negedge clk);
        s_in = '0;
        #1;
        check("rack_at_zero_r_pend", 32'(s_r_pend), 0);
        check("rack_at_zero_err", 32'(s_err), 32'(ErrExp));

        // First completion and RACK together at zero.
        pulse_reset();
        #1;
        check("reset_clears_err", 32'(s_err), 0);
        @(negedge clk);
        s_in = 7'b1111000;
        #1;
        check("early_rack_dn_r_valid", 32'(s_dn_r_valid), 1);
        @(negedge clk);
        s_in = '0;
        #1;
        check("early_rack_r_pend", 32'(s_r_pend), 1);
        check("early_rack_err", 32'(s_err), 32'(ErrExp));
        @(negedge clk);
        s_in = 7'b0001000;
        @(negedge clk);
        s_in = '0;
        #1;
        check("early_rack_drained", 32'(s_r_pend), 0);

        // Asynchronous reset mid-cycle with r_pend=3, b_pend=1 on the large instance.
        @(negedge clk);
        l_in = 7'b0000001;
        @(negedge clk);
        l_in = 7'b1110110;
        @(negedge clk);
        l_in = 7'b1110000;
        @(negedge clk);
        l_in = 7'b1110000;
        @(negedge clk);
        l_in = 7'b0010010;
        #1;
        check("pre_reset_r_pend", 32'(l_r_pend), 3);
        check("pre_reset_b_pend", 32'(l_b_pend), 1);
        check("pre_reset_err", 32'(l_err), 32'(ErrExp));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_r_pend", 32'(l_r_pend), 0);
        check("async_reset_b_pend", 32'(l_b_pend), 0);
        check("async_reset_idle", 32'(l_idle), 1);
        check("async_reset_err", 32'(l_err), 0);
        check("async_reset_up_r_ready", 32'(l_up_r_ready), 1);
        check("async_reset_up_b_ready", 32'(l_up_b_ready), 1);
        @(negedge clk);
        rst  = 1'b0;
        l_in = '0;

        // Random traffic; the bench acts as the ACE master, acking 1..10 cycles late.
        r_model = 0;
        b_model = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            st = '0;
            if (cyc < 2960) begin
                st.r_valid = 1'($urandom_range(0, 1));
                st.r_last  = 1'($urandom_range(0, 1));
                st.r_ready = ($urandom_range(0, 3) != 0);
                st.b_valid = 1'($urandom_range(0, 1));
                st.b_ready = ($urandom_range(0, 3) != 0);
            end
            idx = -1;
            foreach (r_due[i]) if (idx < 0 && r_due[i] <= cyc) idx = i;
            if (idx >= 0) begin
                st.rack = 1'b1;
                r_due.delete(idx);
            end
            idx = -1;
            foreach (b_due[i]) if (idx < 0 && b_due[i] <= cyc) idx = i;
            if (idx >= 0) begin
                st.wack = 1'b1;
                b_due.delete(idx);
            end
            l_in = st;
            #1;
            r_full = (r_model == int'(LargeMax));
            b_full = (b_model == int'(LargeMax));
            check("rnd_r_pend", 32'(l_r_pend), 32'(r_model));
            check("rnd_b_pend", 32'(l_b_pend), 32'(b_model));
            check("rnd_dn_r_valid", 32'(l_dn_r_valid), 32'(st.r_valid & ~r_full));
            check("rnd_up_r_ready", 32'(l_up_r_ready), 32'(st.r_ready & ~r_full));
            check("rnd_dn_b_valid", 32'(l_dn_b_valid), 32'(st.b_valid & ~b_full));
            check("rnd_up_b_ready", 32'(l_up_b_ready), 32'(st.b_ready & ~b_full));
            check("rnd_idle", 32'(l_idle), 32'(r_model == 0 && b_model == 0));
            check("rnd_bound", 32'(l_r_pend <= LW'(LargeMax) && l_b_pend <= LW'(LargeMax)), 1);
            check("rnd_err", 32'(l_err), 0);
            if (st.r_valid && st.r_ready && st.r_last && !r_full) begin
                r_due.push_back(cyc + int'($urandom_range(1, 10)));
                r_model++;
            end
            if (st.b_valid && st.b_ready && !b_full) begin
                b_due.push_back(cyc + int'($urandom_range(1, 10)));
                b_model++;
            end
            if (st.rack) r_model--;
            if (st.wack) b_model--;
        end
        @(negedge clk);
        l_in = '0;
        #1;
        check("drain_r_pend", 32'(l_r_pend), 0);
        check("drain_b_pend", 32'(l_b_pend), 0);
        check("drain_idle", 32'(l_idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
